// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitR,
    StDone
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication from the live access, and load lane
// select plus sign/zero extension from the latched access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    case (st_funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o    = 4'b0011 << st_off_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data_o = {24'h0, shifted[7:0]};
      F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data_o = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: fault decode, req/gnt/rvalid sequencing with a bus timeout,
// and a one-cycle DONE slot where load data and bus errors are presented to the pipeline.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AccessFaultM,
  output logic        BusErrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access, f3_ok, fault, start, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, ld_data;

  lsu_align u_align (
    .st_funct3_i (Funct3M),
    .st_off_i    (ALUResultM[1:0]),
    .st_data_i   (WriteDataM),
    .be_o        (be_new),
    .wdata_o     (wdata_new),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .rdata_i     (bus_rdata),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    access = MemReadM | MemWriteM;
    case (Funct3M)
      F3_B:    f3_ok = 1'b1;
      F3_H:    f3_ok = ~ALUResultM[0];
      F3_W:    f3_ok = (ALUResultM[1:0] == 2'b00);
      F3_BU:   f3_ok = ~MemWriteM;
      F3_HU:   f3_ok = ~MemWriteM & ~ALUResultM[0];
      default: f3_ok = 1'b0;
    endcase
    // Inputs only matter in IDLE; elsewhere M holds the access already in flight.
    fault   = (state_q == StIdle) & access & (~f3_ok | (MemReadM & MemWriteM));
    start   = (state_q == StIdle) & access & ~fault;
    timeout = (cnt_q == 8'(MAX_WAIT - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = {ALUResultM[31:2], 2'b00};
          off_d   = ALUResultM[1:0];
          be_d    = be_new;
          wdata_d = wdata_new;
          we_d    = MemWriteM;
          f3_d    = Funct3M;
          req_d   = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus_gnt) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = we_q ? StDone : StWaitR;
        end else if (timeout) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWaitR: begin
        if (bus_rvalid) begin
          rdata_d = ld_data;
          state_d = StDone;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    StallM       = rst & (start | (state_q == StReq) | (state_q == StWaitR));
    AccessFaultM = fault;
    ReadDataM    = (state_q == StDone) ? rdata_q : 32'h0;
    BusErrM      = (state_q == StDone) & err_q;
    bus_req      = req_q;
    bus_we       = we_q;
    bus_addr     = addr_q;
    bus_be       = be_q;
    bus_wdata    = wdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, extended loads, faults, slow bus,
// timeout and reset in the middle of a read.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, AccessFaultM, BusErrM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit #(.MAX_WAIT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .Funct3M      (Funct3M),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .ReadDataM    (ReadDataM),
    .StallM       (StallM),
    .AccessFaultM (AccessFaultM),
    .BusErrM      (BusErrM),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    Funct3M    = 3'b000;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
  endtask

  // Load with immediate grant and rvalid one cycle after the grant.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    MemReadM = 1'b1; Funct3M = f3; ALUResultM = addr; bus_gnt = 1'b1;
    @(negedge clk); chk({tag, " idle stall"}, 32'(StallM), 32'd1);
    next_cycle();
    @(negedge clk);
    chk({tag, " be"}, 32'(bus_be), 32'(exp_be));
    chk({tag, " we"}, 32'(bus_we), 32'd0);
    next_cycle();
    bus_rvalid = 1'b1; bus_rdata = rdata;
    @(negedge clk); chk({tag, " waitr data"}, ReadDataM, 32'h0);
    next_cycle();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk({tag, " data"}, ReadDataM, exp_data);
    chk({tag, " done stall"}, 32'(StallM), 32'd0);
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    int  n;
    bit  seen_done;
    rst = 1'b0; bus_gnt = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req", 32'(bus_req), 32'd0);
    chk("reset stall", 32'(StallM), 32'd0);
    chk("reset addr", bus_addr, 32'h0);
    chk("reset rdata", ReadDataM, 32'h0);
    rst = 1'b1;
    next_cycle();

    // SW 0x100, grant immediately
    MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h100; WriteDataM = 32'hDEADBEEF;
    bus_gnt = 1'b1;
    @(negedge clk);
    chk("sw idle stall", 32'(StallM), 32'd1);
    chk("sw idle req", 32'(bus_req), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("sw req", 32'(bus_req), 32'd1);
    chk("sw stall", 32'(StallM), 32'd1);
    chk("sw be", 32'(bus_be), 32'hF);
    chk("sw addr", bus_addr, 32'h100);
    chk("sw wdata", bus_wdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    chk("sw done stall", 32'(StallM), 32'd0);
    chk("sw done req", 32'(bus_req), 32'd0);
    chk("sw done err", 32'(BusErrM), 32'd0);
    next_cycle();
    idle_inputs();

    // SB 0x103
    MemWriteM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h103; WriteDataM = 32'h000000A5;
    next_cycle();
    @(negedge clk);
    chk("sb be", 32'(bus_be), 32'h8);
    chk("sb wdata", bus_wdata, 32'hA5A5A5A5);
    chk("sb we", 32'(bus_we), 32'd1);
    chk("sb addr", bus_addr, 32'h100);
    next_cycle();
    next_cycle();
    idle_inputs();

    do_load("lb",  3'b000, 32'h102, 32'h12F45678, 4'b0100, 32'hFFFFFFF4);
    do_load("lbu", 3'b100, 32'h102, 32'h12F45678, 4'b0100, 32'h000000F4);
    do_load("lhu", 3'b101, 32'h102, 32'h12F45678, 4'b1100, 32'h000012F4);
    do_load("lh",  3'b001, 32'h102, 32'hF2345678, 4'b1100, 32'hFFFFF234);
    do_load("lw",  3'b010, 32'h104, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF);

    // Faulting accesses: no bus activity, no stall
    MemReadM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h201;
    @(negedge clk);
    chk("lh mis fault", 32'(AccessFaultM), 32'd1);
    chk("lh mis stall", 32'(StallM), 32'd0);
    next_cycle();
    Funct3M = 3'b010; ALUResultM = 32'h102;
    @(negedge clk);
    chk("lw mis fault", 32'(AccessFaultM), 32'd1);
    chk("lw mis req", 32'(bus_req), 32'd0);
    chk("lw mis stall", 32'(StallM), 32'd0);
    next_cycle();
    MemReadM = 1'b0; MemWriteM = 1'b1; Funct3M = 3'b100; ALUResultM = 32'h200;
    @(negedge clk); chk("sbu illegal fault", 32'(AccessFaultM), 32'd1);
    next_cycle();
    MemReadM = 1'b1; Funct3M = 3'b010;
    @(negedge clk); chk("rd+wr fault", 32'(AccessFaultM), 32'd1);
    next_cycle();
    chk("fault no req", 32'(bus_req), 32'd0);
    idle_inputs();

    // LW with grant after 3 cycles, rvalid 2 cycles after grant
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300; bus_gnt = 1'b0;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("slow req held", 32'(bus_req), 32'd1);
      chk("slow req stall", 32'(StallM), 32'd1);
      next_cycle();
    end
    // rvalid with grant must not be taken as read data
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
    next_cycle();
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk("slow waitr req", 32'(bus_req), 32'd0);
    chk("slow waitr stall", 32'(StallM), 32'd1);
    next_cycle();
    bus_rvalid = 1'b1; bus_rdata = 32'h13572468;
    @(negedge clk); chk("slow waitr stall2", 32'(StallM), 32'd1);
    next_cycle();
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("slow data", ReadDataM, 32'h13572468);
    chk("slow done stall", 32'(StallM), 32'd0);
    next_cycle();
    idle_inputs();

    // Grant never arrives: timeout after 15 cycles in REQ
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h400; bus_gnt = 1'b0;
    next_cycle();
    n = 0; seen_done = 1'b0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      @(negedge clk);
      if (StallM) begin
        n++;
        next_cycle();
      end else begin
        seen_done = 1'b1;
      end
    end
    chk("timeout cycles", 32'(n), 32'd15);
    chk("timeout buserr", 32'(BusErrM), 32'd1);
    chk("timeout data", ReadDataM, 32'h0);
    chk("timeout req", 32'(bus_req), 32'd0);
    next_cycle();
    idle_inputs();
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("late rvalid err", 32'(BusErrM), 32'd0);
    chk("late rvalid data", ReadDataM, 32'h0);
    next_cycle();
    idle_inputs();

    // Reset while waiting for read data
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h500; bus_gnt = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rst mid req", 32'(bus_req), 32'd0);
    chk("rst mid stall", 32'(StallM), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk);
    chk("rst late rvalid stall", 32'(StallM), 32'd0);
    chk("rst late rvalid data", ReadDataM, 32'h0);
    next_cycle();
    idle_inputs();
    do_load("lw after rst", 3'b010, 32'h500, 32'h0BADF00D, 4'b1111, 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
